// File: rtl/dsa_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dsa_mem_arbiter
//
// Purpose:
//   Single-port memory arbiter for the DSA pixel datapath. Three requesters
//   share one synchronous-read memory:
//     - ext : host access (read or write), always highest priority
//     - wr  : datapath writeback
//     - rd  : pixel-fetch read, which may lock the memory for a burst
//   At most one requester is granted per cycle. Grants are combinational from
//   the live requests and the registered state. The granted command drives the
//   mem_* port in the same cycle. Read data returns one cycle later on rdata,
//   tagged by rd_valid or ext_rvalid.
//
// Arbitration:
//   ARB     : ext > rd (starved, wait_cnt >= STARVE_LIMIT) > wr > rd
//   RD_LOCK : ext > rd > wr (wr only when rd_req is low)
//   ARB -> RD_LOCK when rd is granted with rd_lock high.
//   RD_LOCK -> ARB when rd_req or rd_lock is low, unless ext is granted that
//   cycle (a host access never disturbs a running burst).
//
// Parameters:
//   ADDR_WIDTH   : width of every address port
//   STARVE_LIMIT : fetch wait cycles before rd is promoted above wr
//
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   ext_req/ext_we/ext_addr/ext_wdata : host request, ext_gnt grant
//   wr_req/wr_addr/wr_wdata           : writeback request, wr_gnt grant
//   rd_req/rd_lock/rd_addr            : fetch request, rd_gnt grant
//   rd_valid, ext_rvalid              : rdata qualifiers (1-cycle latency)
//   rdata                             : pass-through of mem_data_out
//   mem_read_en/mem_write_en/mem_addr/mem_data_in/mem_data_out : memory port
//   conflict_count                    : cycles with >= 2 concurrent requests
//
// Build option:
//   DSA_ARB_STATS_EN : when defined, conflict_count is a live 32-bit wrapping
//                      counter; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module dsa_mem_arbiter #(
    parameter int ADDR_WIDTH   = 18,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [7:0]            ext_wdata,
    output logic                  ext_gnt,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_wdata,
    output logic                  wr_gnt,

    input  logic                  rd_req,
    input  logic                  rd_lock,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,

    output logic                  rd_valid,
    output logic                  ext_rvalid,
    output logic [7:0]            rdata,

    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data_in,
    input  logic [7:0]            mem_data_out,

    output logic [31:0]           conflict_count
);

    // Wait counter only needs to reach STARVE_LIMIT, where it saturates.
    localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ARB     = 1'b0,
        RD_LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic                rd_valid_q,   rd_valid_d;
    logic                ext_rvalid_q, ext_rvalid_d;
    logic                starved;

    assign starved = (wait_q >= WAIT_MAX);

    // -------------------------------------------------------------------------
    // Grant selection and next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ext_gnt = 1'b0;
        wr_gnt  = 1'b0;
        rd_gnt  = 1'b0;

        // Reset holds every grant low; the register block forces ARB.
        if (!rst) begin
            case (state_q)
                ARB: begin
                    if (ext_req) begin
                        ext_gnt = 1'b1;
                    end else if (rd_req && starved) begin
                        rd_gnt = 1'b1;
                    end else if (wr_req) begin
                        wr_gnt = 1'b1;
                    end else if (rd_req) begin
                        rd_gnt = 1'b1;
                    end

                    if (rd_gnt && rd_lock) begin
                        state_d = RD_LOCK;
                    end
                end

                RD_LOCK: begin
                    // wr can only win here when rd has nothing to ask for.
                    if (ext_req) begin
                        ext_gnt = 1'b1;
                    end else if (rd_req) begin
                        rd_gnt = 1'b1;
                    end else if (wr_req) begin
                        wr_gnt = 1'b1;
                    end

                    // A host access steals one cycle but leaves the burst
                    // ownership untouched.
                    if (!ext_gnt && (!rd_req || !rd_lock)) begin
                        state_d = ARB;
                    end
                end

                default: state_d = ARB;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory command mux: the single granted command, or all zeros when idle
    // -------------------------------------------------------------------------
    always_comb begin
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;

        if (ext_gnt) begin
            mem_read_en  = ~ext_we;
            mem_write_en = ext_we;
            mem_addr     = ext_addr;
            mem_data_in  = ext_we ? ext_wdata : 8'd0;
        end else if (wr_gnt) begin
            mem_write_en = 1'b1;
            mem_addr     = wr_addr;
            mem_data_in  = wr_wdata;
        end else if (rd_gnt) begin
            mem_read_en  = 1'b1;
            mem_addr     = rd_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter and read-valid tags
    // -------------------------------------------------------------------------
    always_comb begin
        wait_d = '0;
        if (rd_req && !rd_gnt) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end

        rd_valid_d   = rd_gnt;
        ext_rvalid_d = ext_gnt & ~ext_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            wait_q       <= '0;
            rd_valid_q   <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            rd_valid_q   <= rd_valid_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    // The tag registers still hold the pre-reset grant during the first reset
    // cycle, so they are masked to keep a read issued just before reset from
    // ever appearing valid.
    assign rd_valid   = rd_valid_q   & ~rst;
    assign ext_rvalid = ext_rvalid_q & ~rst;
    assign rdata      = mem_data_out;

    // -------------------------------------------------------------------------
    // Optional contention statistics
    // -------------------------------------------------------------------------
`ifdef DSA_ARB_STATS_EN
    logic [31:0] conflict_q, conflict_d;
    logic        multi_req;

    assign multi_req = (ext_req & wr_req) | (ext_req & rd_req) | (wr_req & rd_req);

    always_comb begin
        conflict_d = conflict_q;
        if (multi_req) begin
            conflict_d = conflict_q + 32'd1;   // wraps naturally at 2^32
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count = rst ? 32'd0 : conflict_q;
`else
    assign conflict_count = 32'd0;
`endif

endmodule

// File: tb/tb_dsa_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dsa_mem_arbiter
//
// Directed bench for dsa_mem_arbiter (ADDR_WIDTH=18, STARVE_LIMIT=8).
// A small behavioural memory answers mem_* so rdata can be checked against
// the bytes written earlier. Grants are checked as {ext_gnt, wr_gnt, rd_gnt}.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dsa_mem_arbiter;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [7:0]    ext_wdata;
    logic          ext_gnt;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_wdata;
    logic          wr_gnt;
    logic          rd_req, rd_lock;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid, ext_rvalid;
    logic [7:0]    rdata;
    logic          mem_read_en, mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data_in;
    logic [7:0]    mem_data_out;
    logic [31:0]   conflict_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dsa_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_gnt        (ext_gnt),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_wdata       (wr_wdata),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_lock        (rd_lock),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .ext_rvalid     (ext_rvalid),
        .rdata          (rdata),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .conflict_count (conflict_count)
    );

    // Behavioural memory with one-cycle read latency.
    logic [7:0] mem_model [256];
    logic [7:0] mem_rd_q;
    assign mem_data_out = mem_rd_q;

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        mem_rd_q = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_write_en) mem_model[mem_addr[7:0]] <= mem_data_in;
        if (mem_read_en)  mem_rd_q <= mem_model[mem_addr[7:0]];
    end

    // Reference for conflict_count, built from the request inputs only.
    logic [31:0] exp_cc = 32'd0;
    always @(posedge clk) begin
`ifdef DSA_ARB_STATS_EN
        if (rst)
            exp_cc <= 32'd0;
        else if ((ext_req & wr_req) | (ext_req & rd_req) | (wr_req & rd_req))
            exp_cc <= exp_cc + 32'd1;
`else
        exp_cc <= 32'd0;
`endif
    end

    wire [2:0] gnt = {ext_gnt, wr_gnt, rd_gnt};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle's requests, then let combinational outputs settle.
    task automatic drive(input logic e, input logic ewe, input logic [AW-1:0] ea,
                         input logic [7:0] ed, input logic w, input logic [AW-1:0] wa,
                         input logic [7:0] wd, input logic r, input logic lk,
                         input logic [AW-1:0] ra);
        ext_req = e;  ext_we = ewe; ext_addr = ea; ext_wdata = ed;
        wr_req  = w;  wr_addr = wa; wr_wdata = wd;
        rd_req  = r;  rd_lock = lk; rd_addr = ra;
        #1;
    endtask

    task automatic idle;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();

        // ---- Reset: grants forced low even with a request present ----------
        drive(0, 0, 0, 0, 1, 18'h10, 8'hA5, 0, 0, 0);
        check_vec("rst_gnt",    32'(gnt), 32'h0);
        check_vec("rst_mem_we", 32'(mem_write_en), 32'h0);
        check_vec("rst_rvalid", 32'({rd_valid, ext_rvalid}), 32'h0);
        check_vec("rst_cc",     conflict_count, 32'h0);
        tick();
        rst = 1'b0;

        // ---- Writeback alone, then host write ------------------------------
        drive(0, 0, 0, 0, 1, 18'h10, 8'hA5, 0, 0, 0);
        check_vec("wr_gnt",   32'(gnt), 32'b010);
        check_vec("wr_mem",   {mem_write_en, mem_read_en, 6'd0, mem_data_in, 16'(mem_addr)},
                              {1'b1, 1'b0, 6'd0, 8'hA5, 16'h0010});
        tick();
        drive(1, 1, 18'h20, 8'h3C, 0, 0, 0, 0, 0, 0);
        check_vec("extw_gnt", 32'(gnt), 32'b100);
        check_vec("extw_mem", {mem_write_en, mem_read_en, 6'd0, mem_data_in, 16'(mem_addr)},
                              {1'b1, 1'b0, 6'd0, 8'h3C, 16'h0020});
        tick();

        // ---- No request: idle memory port ----------------------------------
        idle();
        check_vec("idle_gnt", 32'(gnt), 32'h0);
        check_vec("idle_mem", {mem_write_en, mem_read_en, 6'd0, mem_data_in, 16'(mem_addr)}, 32'h0);
        tick();

        // ---- Host read beats fetch read ------------------------------------
        drive(1, 0, 18'h20, 0, 0, 0, 0, 1, 0, 18'h10);
        check_vec("ext_vs_rd_gnt", 32'(gnt), 32'b100);
        check_vec("ext_rd_strobe", 32'({mem_read_en, mem_write_en}), 32'b10);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 18'h10);
        check_vec("ext_rvalid",   32'({ext_rvalid, rd_valid}), 32'b10);
        check_vec("ext_rdata",    32'(rdata), 32'h3C);
        check_vec("cc_after_ext", conflict_count, exp_cc);
        check_vec("rd_late_gnt",  32'(gnt), 32'b001);
        tick();
        idle();
        check_vec("rd_valid",     32'({ext_rvalid, rd_valid}), 32'b01);
        check_vec("rd_rdata",     32'(rdata), 32'hA5);
        tick();

        // ---- Starvation promotion: wr 0-7, rd 8, wr 9 -----------------------
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0, 0, 1, 18'h30, 8'h77, 1, 0, 18'h30);
            check_vec($sformatf("starve_c%0d", c), 32'(gnt), (c == 8) ? 32'b001 : 32'b010);
            if (c == 9) begin
                check_vec("starve_rvalid", 32'(rd_valid), 32'h1);
                check_vec("starve_rdata",  32'(rdata), 32'h77);
            end
            tick();
        end
        idle();
        check_vec("starve_cc", conflict_count, exp_cc);
        tick();

        // ---- Lock burst: rd wins 8-11 despite wr, wr in cycle after unlock --
        for (int c = 0; c < 13; c++) begin
            if (c < 11)       drive(0, 0, 0, 0, 1, 18'h40, 8'h11, 1, 1, 18'h30);
            else if (c == 11) drive(0, 0, 0, 0, 1, 18'h40, 8'h11, 1, 0, 18'h30);
            else              drive(0, 0, 0, 0, 1, 18'h40, 8'h11, 0, 0, 18'h30);
            check_vec($sformatf("lock_c%0d", c), 32'(gnt),
                      (c >= 8 && c <= 11) ? 32'b001 : 32'b010);
            tick();
        end
        idle();
        tick();

        // ---- Host access in burst cycle 2 keeps RD_LOCK --------------------
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 18'h40);
        check_vec("burst_c0", 32'(gnt), 32'b001);
        tick();
        drive(0, 0, 0, 0, 1, 18'h41, 8'h22, 1, 1, 18'h40);
        check_vec("burst_c1", 32'(gnt), 32'b001);
        tick();
        drive(1, 1, 18'h50, 8'h99, 1, 18'h41, 8'h22, 1, 1, 18'h40);
        check_vec("burst_c2_ext", 32'(gnt), 32'b100);
        tick();
        drive(0, 0, 0, 0, 1, 18'h41, 8'h22, 1, 1, 18'h40);
        check_vec("burst_c3_rd",  32'(gnt), 32'b001);
        check_vec("burst_c3_rvalid", 32'({ext_rvalid, rd_valid}), 32'b00);
        tick();
        drive(0, 0, 0, 0, 1, 18'h41, 8'h22, 0, 0, 18'h40);
        check_vec("burst_c4_wr",  32'(gnt), 32'b010);
        check_vec("burst_c4_rdata", 32'(rdata), 32'h11);
        tick();
        idle();
        tick();

        // ---- Reset in RD_LOCK right after an rd grant -----------------------
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 18'h50);
        check_vec("rstlock_c0", 32'(gnt), 32'b001);
        tick();
        drive(0, 0, 0, 0, 1, 18'h60, 8'h5A, 1, 1, 18'h50);
        check_vec("rstlock_c1", 32'(gnt), 32'b001);
        tick();
        rst = 1'b1;
        #1;
        check_vec("rstlock_gnt",    32'(gnt), 32'h0);
        check_vec("rstlock_strobe", 32'({mem_read_en, mem_write_en}), 32'h0);
        check_vec("rstlock_rvalid", 32'(rd_valid), 32'h0);
        check_vec("rstlock_cc",     conflict_count, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check_vec("post_rst_rvalid", 32'({ext_rvalid, rd_valid}), 32'h0);
        check_vec("post_rst_cc",     conflict_count, 32'h0);
        check_vec("post_rst_wr",     32'(gnt), 32'b010);
        tick();
        check_vec("post_rst_wr2",    32'(gnt), 32'b010);
        check_vec("post_rst_cc2",    conflict_count, exp_cc);
        tick();
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dsa_mem_arbiter.md
DSA_MEM_ARBITER -- requirements
Module: dsa_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 18: width of all address ports.
REQ-002 Parameter STARVE_LIMIT, default 8: wait cycles before a pending fetch read is promoted above writes.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ext_req  input  1  host access request; highest priority.
REQ-006 ext_we  input  1  host access type: 1 = write, 0 = read.
REQ-007 ext_addr  input  ADDR_WIDTH  host address.
REQ-008 ext_wdata  input  8  host write data.
REQ-009 ext_gnt  output  1  host access issued this cycle.
REQ-010 wr_req  input  1  writeback request from the datapath result path.
REQ-011 wr_addr  input  ADDR_WIDTH  writeback address.
REQ-012 wr_wdata  input  8  writeback pixel.
REQ-013 wr_gnt  output  1  writeback issued this cycle.
REQ-014 rd_req  input  1  pixel-fetch read request.
REQ-015 rd_lock  input  1  fetch requests to hold ownership for a multi-read burst (p00..p11).
REQ-016 rd_addr  input  ADDR_WIDTH  fetch read address.
REQ-017 rd_gnt  output  1  fetch read issued this cycle.
REQ-018 rd_valid  output  1  rdata belongs to the fetch read granted in the previous cycle.
REQ-019 ext_rvalid  output  1  rdata belongs to the host read granted in the previous cycle.
REQ-020 rdata  output  8  read data; pass-through of mem_data_out.
REQ-021 mem_read_en  output  1  memory read strobe.
REQ-022 mem_write_en  output  1  memory write strobe.
REQ-023 mem_addr  output  ADDR_WIDTH  memory address.
REQ-024 mem_data_in  output  8  memory write data.
REQ-025 mem_data_out  input  8  memory read data, valid one cycle after mem_read_en.
REQ-026 conflict_count  output  32  cycles with two or more simultaneous requests.

Function
REQ-027 At most one grant SHALL be asserted per cycle. Grants SHALL be combinational from the current requests and the registered state. The granted port's command SHALL drive mem_* in the same cycle.
REQ-028 When no grant is asserted, mem_read_en and mem_write_en SHALL be 0, and mem_addr and mem_data_in SHALL be 0.
REQ-029 FSM states SHALL be ARB and RD_LOCK.
REQ-030 In ARB, priority SHALL be: ext, then rd if wait_cnt >= STARVE_LIMIT, then wr, then rd.
REQ-031 In RD_LOCK, priority SHALL be: ext, then rd, then wr. wr SHALL be granted only when rd_req = 0.
REQ-032 ARB SHALL go to RD_LOCK on any cycle with rd_gnt = 1 and rd_lock = 1.
REQ-033 RD_LOCK SHALL return to ARB on any cycle with rd_req = 0 or rd_lock = 0. An ext grant SHALL NOT change the state.
REQ-034 wait_cnt (saturating at STARVE_LIMIT) SHALL increment on each cycle with rd_req = 1 and rd_gnt = 0. It SHALL clear on rd_gnt or when rd_req = 0.
REQ-035 rd_valid and ext_rvalid SHALL be registered copies of (rd_gnt) and (ext_gnt & ~ext_we) respectively, giving 1-cycle read latency.
REQ-036 conflict_count SHALL increment by 1 per cycle in which at least two of ext_req, wr_req, rd_req are high. It SHALL wrap at 2^32.
REQ-037 Any request that is not granted SHALL be held stable by its requester. The arbiter SHALL NOT queue requests.

Reset
REQ-038 While rst = 1: all grants and mem strobes SHALL be 0. The state SHALL be forced to ARB. wait_cnt, rd_valid, ext_rvalid and conflict_count SHALL be forced to 0.
REQ-039 Reset asserted mid-burst SHALL discard the lock. A read granted in the cycle before reset SHALL NOT produce a valid pulse after reset.

Configuration
REQ-040 Macro DSA_ARB_STATS_EN: when defined, conflict_count SHALL be implemented per REQ-036. When undefined, conflict_count SHALL be tied to 32'd0 and no counter logic SHALL be present.

Verification
REQ-041 ext_req=1, ext_we=0 and rd_req=1 in the same cycle -> ext_gnt=1, rd_gnt=0; next cycle ext_rvalid=1, rd_valid=0; conflict_count=1 (with stats enabled).
REQ-042 wr_req held high with rd_req held high from cycle 0 -> wr granted cycles 0-7; rd_gnt=1 in cycle 8 (STARVE_LIMIT=8); wr_gnt in cycle 9.
REQ-043 rd_req=1, rd_lock=1 for 4 cycles with wr_req=1 throughout -> rd_gnt in 4 consecutive cycles; wr_gnt first asserted in the cycle after rd_lock drops.
REQ-044 Lock burst with ext_req=1 pulsed in burst cycle 2 -> ext_gnt in that cycle; rd resumes in the next cycle; state remains RD_LOCK.
REQ-045 rst asserted in RD_LOCK in the cycle after an rd_gnt -> rd_valid=0, state ARB, all counters 0; the first post-reset wr_req is granted immediately.
